// File: rtl/delay_countdown_pkg.sv
// Shared types and defaults for the start-lights delay countdown and its
// millisecond prescaler.
package delay_countdown_pkg;

  localparam int DELAY_W_DEF  = 14;
  localparam int TICK_DIV_DEF = 50000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2
  } state_t;

endpackage

// File: rtl/delay_countdown_ms_tick.sv
// Millisecond prescaler: counts enabled cycles and pulses tick on the last
// cycle of each TICK_DIV period; held at zero whenever disabled.
module ms_tick
  import delay_countdown_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && w_last;

endmodule

// File: rtl/delay_countdown.sv
// Lights-out delay timer: counts delay_ms milliseconds after an accepted start
// and emits a one-cycle time_out pulse, unless aborted or reset first.
module delay_countdown
  import delay_countdown_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DELAY_W  = DELAY_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DELAY_W-1:0] delay_ms,
  input  logic               abort,
  output logic               busy,
  output logic               time_out,
  output logic [DELAY_W-1:0] remaining
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DELAY_W-1:0] r_remaining;
  logic [DELAY_W-1:0] w_remaining_nxt;
  logic [DELAY_W-1:0] w_remaining_dec;
  logic               w_tick;
  logic               w_cnt_en;

  // Saturating decrement keeps remaining from ever wrapping below zero.
  function automatic logic [DELAY_W-1:0] sat_dec(input logic [DELAY_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // Abort drops the enable so the prescaler is already zero on entry to IDLE.
  assign w_cnt_en = (r_state == COUNT) && !abort;

  ms_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_ms_tick (
    .clk (clk),
    .rst (rst),
    .en  (w_cnt_en),
    .tick(w_tick)
  );

  assign w_remaining_dec = sat_dec(r_remaining);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    unique case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_remaining_nxt = delay_ms;
          w_state_nxt     = (delay_ms == '0) ? FIRE : COUNT;
        end
      end
      COUNT: begin
        if (abort) begin
          w_state_nxt     = IDLE;
          w_remaining_nxt = '0;
        end else if (w_tick) begin
          w_remaining_nxt = w_remaining_dec;
          if (w_remaining_dec == '0) begin
            w_state_nxt = FIRE;
          end
        end
      end
      FIRE: begin
        w_state_nxt = IDLE;
        if (abort) begin
          w_remaining_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_remaining_nxt = '0;
      end
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign time_out  = (r_state == FIRE) && !abort;
  assign remaining = r_remaining;

endmodule

// File: tb/tb_delay_countdown.sv
// Bench for delay_countdown with a 4-cycle millisecond tick.
module tb_delay_countdown;
  import delay_countdown_pkg::*;

  localparam int TD = 4;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] delay_ms = '0;
  logic          busy;
  logic          time_out;
  logic [DW-1:0] remaining;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];

  typedef struct {
    int delay;
    int exp_to;
  } vec_t;

  vec_t vecs[6];

  delay_countdown #(
    .TICK_DIV(TD),
    .DELAY_W (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .delay_ms (delay_ms),
    .abort    (abort),
    .busy     (busy),
    .time_out (time_out),
    .remaining(remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle count %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic issue(input int d, input int exp_off, output int base);
    @(negedge clk);
    #1;
    start    = 1'b1;
    delay_ms = DW'(d);
    base     = cyc;
    if (exp_off >= 0) exp_q.push_back(base + exp_off);
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  // Every pulse must match the oldest outstanding expected expiry cycle.
  always @(negedge clk) begin
    #2;
    if (time_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("time_out_unexpected", cyc, -1);
      end else begin
        chk("time_out_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  initial begin
    int base;
    int b2;
    vecs[0] = '{3, 13};
    vecs[1] = '{0, 1};
    vecs[2] = '{1, 5};
    vecs[3] = '{2, 9};
    vecs[4] = '{6, 25};
    vecs[5] = '{11, 45};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_remaining", int'(remaining), 0);
    chk("reset_time_out", int'(time_out), 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      issue(vecs[v].delay, vecs[v].exp_to, base);
      chk("vec_busy_start", int'(busy), 1);
      chk("vec_remaining_start", int'(remaining), vecs[v].delay);
      for (int i = 1; i < vecs[v].delay; i++) begin
        goto(base + TD * i);
        chk("vec_remaining_before_step", int'(remaining), vecs[v].delay - i + 1);
        goto(base + 1 + TD * i);
        chk("vec_remaining_after_step", int'(remaining), vecs[v].delay - i);
      end
      goto(base + vecs[v].exp_to + 1);
      chk("vec_busy_end", int'(busy), 0);
      chk("vec_remaining_end", int'(remaining), 0);
    end

    // Abort mid-countdown: no pulse, outputs cleared next cycle.
    issue(5, -1, base);
    goto(base + 7);
    abort = 1'b1;
    goto(base + 8);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_remaining", int'(remaining), 0);
    goto(base + 30);
    chk("abort_stays_idle", int'(busy), 0);

    // Abort during FIRE gates that cycle's pulse.
    issue(1, -1, base);
    goto(base + 5);
    chk("fire_busy", int'(busy), 1);
    abort = 1'b1;
    goto(base + 6);
    abort = 1'b0;
    chk("fire_abort_busy", int'(busy), 0);
    chk("fire_abort_remaining", int'(remaining), 0);

    // Restarts while busy, in COUNT and in FIRE, are ignored.
    issue(2, 9, base);
    goto(base + 3);
    start    = 1'b1;
    delay_ms = DW'(9);
    goto(base + 4);
    start = 1'b0;
    chk("restart_remaining_hold", int'(remaining), 2);
    goto(base + 5);
    chk("restart_remaining_step", int'(remaining), 1);
    goto(base + 9);
    start = 1'b1;
    goto(base + 10);
    start = 1'b0;
    chk("restart_fire_busy", int'(busy), 0);
    goto(base + 40);
    chk("restart_idle_late", int'(busy), 0);

    // Reset mid-countdown, then a fresh short countdown.
    issue(4, -1, base);
    goto(base + 6);
    rst = 1'b1;
    goto(base + 7);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_remaining", int'(remaining), 0);
    chk("midrst_time_out", int'(time_out), 0);
    goto(base + 25);
    issue(1, 5, b2);
    goto(b2 + 7);
    chk("post_rst_busy_end", int'(busy), 0);

    // Reset and abort each beat a simultaneous start in IDLE.
    @(negedge clk);
    #1;
    rst = 1'b1; start = 1'b1; delay_ms = DW'(5);
    @(negedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_over_start_busy", int'(busy), 0);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b0; start = 1'b0;
    chk("abort_over_start_busy", int'(busy), 0);
    chk("abort_over_start_remaining", int'(remaining), 0);

    // Longest lights-out delay.
    issue(16000, 64001, base);
    chk("long_remaining_start", int'(remaining), 16000);
    goto(base + 32001);
    chk("long_remaining_mid", int'(remaining), 8000);
    goto(base + 64000);
    chk("long_remaining_last", int'(remaining), 1);
    chk("long_busy_last", int'(busy), 1);
    goto(base + 64002);
    chk("long_busy_end", int'(busy), 0);
    chk("long_remaining_end", int'(remaining), 0);

    goto(cyc + 5);
    chk("pending_time_out", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_countdown.md
DELAY_COUNTDOWN -- requirements
Module: delay_countdown

Interface
REQ-001 Parameter TICK_DIV, default 50000, clock cycles per millisecond tick (50 MHz clk); legal range 2..65535.
REQ-002 Parameter DELAY_W, default 14, width of the delay and remaining-count fields.
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port start  in  1  one-cycle request to begin a countdown; sampled only in IDLE.
REQ-006 Port delay_ms  in  DELAY_W  requested delay in milliseconds (pseudo-random lights-out value); latched when start is accepted.
REQ-007 Port abort  in  1  cancels an active countdown (e.g. jump start).
REQ-008 Port busy  out  1  high whenever state is not IDLE.
REQ-009 Port time_out  out  1  single-cycle pulse marking expiry of the delay.
REQ-010 Port remaining  out  DELAY_W  milliseconds left in the current countdown.

Function
REQ-011 FSM states SHALL be IDLE, COUNT and FIRE, and outputs SHALL be registered Moore outputs.
REQ-012 IDLE with start=1 and abort=0: latch delay_ms into remaining, clear the prescaler, next state COUNT if delay_ms>0, else FIRE.
REQ-013 COUNT: prescaler increments each cycle; at TICK_DIV-1 it wraps to 0 and remaining decrements by 1.
REQ-014 COUNT: the edge that decrements remaining from 1 to 0 SHALL also move the state to FIRE.
REQ-015 FIRE: time_out=1 for exactly one cycle; next state IDLE unconditionally.
REQ-016 Latency: start sampled at edge k with delay D SHALL give time_out high in cycle k+1+D*TICK_DIV, covering D=0.
REQ-017 start while busy=1, including in FIRE, SHALL be ignored; the latched delay is unaffected.
REQ-018 abort=1 in COUNT or FIRE: next state IDLE, remaining cleared to 0, no time_out pulse; abort in FIRE SHALL suppress that cycle's pulse (time_out is gated by abort).
REQ-019 abort and start together in IDLE: abort wins; state stays IDLE.
REQ-020 remaining SHALL never wrap below 0; in IDLE it holds 0 after FIRE or abort.
REQ-021 The prescaler SHALL be ceil(log2(TICK_DIV)) bits wide and SHALL be held at 0 outside COUNT.
REQ-022 delay_ms values up to 2^DELAY_W-1 SHALL be counted exactly, with no truncation.

Reset
REQ-023 rst=1 at any edge, including mid-countdown, SHALL force state IDLE, prescaler 0, remaining 0, busy 0 and time_out 0 on the following cycle.
REQ-024 rst SHALL take priority over start and abort, and no time_out pulse SHALL follow a reset.

Structure
REQ-025 A shared package SHALL hold the state enumeration (IDLE, COUNT, FIRE) and the DELAY_W default constant.
REQ-026 The millisecond prescaler SHALL be a separate sub-module, ms_tick (inputs clk, rst, en; output tick), which is reusable by the lights sequencer.
REQ-027 delay_countdown SHALL instantiate exactly one ms_tick; the FSM and remaining counter SHALL live in the top module.

Verification (TICK_DIV=4 in simulation)
REQ-028 start at cycle 0, delay_ms=3 -> busy 1 from cycle 1; remaining 3,2,1 stepping at cycles 5,9; time_out high only in cycle 13.
REQ-029 start at cycle 0, delay_ms=0 -> time_out high in cycle 1, busy high in cycle 1 only, remaining 0.
REQ-030 delay_ms=5, abort at cycle 7 -> busy 0 and remaining 0 from cycle 8; no time_out within 30 cycles.
REQ-031 delay_ms=2, second start with delay_ms=9 at cycle 3 -> time_out high only in cycle 9; no second pulse.
REQ-032 delay_ms=4, rst at cycle 6 -> all outputs 0 from cycle 7; a fresh start with delay_ms=1 times out 5 cycles after acceptance.
REQ-033 delay_ms=16000 (maximum lights-out value) -> time_out high exactly in cycle 64001; remaining decrements monotonically with no wrap.
